// File: rtl/agen_split_unit.sv
// Stage-2 address generator: linear address, segment-limit check, line-split into two parts.
// Latency: 1 cycle from accepted request to V_OUT; a split request occupies two output cycles.
// Backpressure: outputs hold while V_OUT && !READY_IN; READY_OUT drops in SPLIT1 or when the last part is not retiring.
module agen_split_unit #(
   parameter int ADDR_W      = 32,
   parameter int LINE_BYTES  = 16,
   parameter int CHECK_LIMIT = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              FLUSH,
   input  logic              V_IN,
   output logic              READY_OUT,
   input  logic [ADDR_W-1:0] BASE_DISP,
   input  logic [ADDR_W-1:0] SIB_OFFSET,
   input  logic [ADDR_W-1:0] SEG_BASE,
   input  logic [ADDR_W-1:0] SEG_LIMIT,
   input  logic [1:0]        SIZE,
   input  logic              WR_IN,
   output logic              V_OUT,
   input  logic              READY_IN,
   output logic [ADDR_W-1:0] ADDR_OUT,
   output logic [3:0]        BYTES_OUT,
   output logic              PART_OUT,
   output logic              LAST_OUT,
   output logic              WR_OUT,
   output logic              SEG_LIMIT_EXC_OUT
);

   localparam int LB_W = $clog2(LINE_BYTES);

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_SPLIT1 = 2'd2;

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        bytes_q;
   logic              part_q;
   logic              last_q;
   logic              wr_q;
   logic              exc_q;
   logic [ADDR_W-1:0] p1_addr_q;
   logic [3:0]        p1_bytes_q;

   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] lin;
   logic [3:0]        n_bytes;
   logic [ADDR_W:0]   end_off;
   logic              exc;
   logic [LB_W-1:0]   lo;
   logic              split;
   logic [3:0]        p0_bytes;
   logic [3:0]        p1_bytes;
   logic [ADDR_W-1:0] p1_addr;
   logic              can_load;
   logic              load;

   // Address arithmetic, limit check and split decision for the incoming request
   always_comb begin
      off      = BASE_DISP + SIB_OFFSET;
      lin      = SEG_BASE + off;
      n_bytes  = 4'd1 << SIZE;
      // One extra bit so that a wrap past 2^ADDR_W lands above any limit
      end_off  = {1'b0, off} + (ADDR_W+1)'(n_bytes) - (ADDR_W+1)'(1);
      exc      = (CHECK_LIMIT != 0) && (end_off > {1'b0, SEG_LIMIT});
      lo       = lin[LB_W-1:0];
      // A faulting access is reported whole, never split
      split    = ((int'(lo) + int'(n_bytes)) > LINE_BYTES) && !exc;
      // Only meaningful when split: then lo > LINE_BYTES-8, so the result is 1..7
      p0_bytes = 4'(LINE_BYTES - int'(lo));
      p1_bytes = n_bytes - p0_bytes;
      p1_addr  = lin + ADDR_W'(p0_bytes);
   end

   // Acceptance: empty, or the shown last part retires this cycle
   always_comb begin
      can_load  = (state == ST_EMPTY) || ((state == ST_HOLD) && READY_IN);
      READY_OUT = !RST && !FLUSH && can_load;
      load      = READY_OUT && V_IN;
   end

   // Output-part state machine with registered output fields
   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         state      <= ST_EMPTY;
         addr_q     <= '0;
         bytes_q    <= '0;
         part_q     <= 1'b0;
         last_q     <= 1'b0;
         wr_q       <= 1'b0;
         exc_q      <= 1'b0;
         p1_addr_q  <= '0;
         p1_bytes_q <= '0;
      end else if (load) begin
         state      <= split ? ST_SPLIT1 : ST_HOLD;
         addr_q     <= lin;
         bytes_q    <= split ? p0_bytes : n_bytes;
         part_q     <= 1'b0;
         last_q     <= !split;
         wr_q       <= WR_IN;
         exc_q      <= exc;
         p1_addr_q  <= p1_addr;
         p1_bytes_q <= p1_bytes;
      end else if ((state == ST_HOLD) && READY_IN) begin
         state <= ST_EMPTY;
      end else if ((state == ST_SPLIT1) && READY_IN) begin
         state   <= ST_HOLD;
         addr_q  <= p1_addr_q;
         bytes_q <= p1_bytes_q;
         part_q  <= 1'b1;
         last_q  <= 1'b1;
      end
   end

   // Registered fields drive the memory port directly
   always_comb begin
      V_OUT             = (state != ST_EMPTY);
      ADDR_OUT          = addr_q;
      BYTES_OUT         = bytes_q;
      PART_OUT          = part_q;
      LAST_OUT          = last_q;
      WR_OUT            = wr_q;
      SEG_LIMIT_EXC_OUT = exc_q;
   end

endmodule

// File: tb/tb_agen_split_unit.sv
// Directed bench for agen_split_unit with hand-computed expected values.
// Inputs are driven at the negative edge; outputs are sampled there too.
// Ends with one summary line of comparison and failure counts.
module tb_agen_split_unit;

   logic        CLK = 1'b0;
   logic        RST, FLUSH, V_IN, READY_IN, WR_IN;
   logic [31:0] BASE_DISP, SIB_OFFSET, SEG_BASE, SEG_LIMIT;
   logic [1:0]  SIZE;
   logic        READY_OUT, V_OUT, PART_OUT, LAST_OUT, WR_OUT, SEG_LIMIT_EXC_OUT;
   logic [31:0] ADDR_OUT;
   logic [3:0]  BYTES_OUT;

   int total = 0;
   int bad   = 0;

   always #5 CLK = ~CLK;

   agen_split_unit #(.ADDR_W(32), .LINE_BYTES(16), .CHECK_LIMIT(1)) dut (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .V_IN(V_IN), .READY_OUT(READY_OUT),
      .BASE_DISP(BASE_DISP), .SIB_OFFSET(SIB_OFFSET), .SEG_BASE(SEG_BASE),
      .SEG_LIMIT(SEG_LIMIT), .SIZE(SIZE), .WR_IN(WR_IN), .V_OUT(V_OUT),
      .READY_IN(READY_IN), .ADDR_OUT(ADDR_OUT), .BYTES_OUT(BYTES_OUT),
      .PART_OUT(PART_OUT), .LAST_OUT(LAST_OUT), .WR_OUT(WR_OUT),
      .SEG_LIMIT_EXC_OUT(SEG_LIMIT_EXC_OUT)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to the next negative edge (sampling / driving point)
   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic req(input logic [31:0] sb, input logic [31:0] bd, input logic [31:0] sib,
                      input logic [31:0] lim, input logic [1:0] sz, input logic wr);
      V_IN = 1'b1; SEG_BASE = sb; BASE_DISP = bd; SIB_OFFSET = sib;
      SEG_LIMIT = lim; SIZE = sz; WR_IN = wr;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] a, input logic [3:0] b,
                             input logic p, input logic l, input logic e);
      check({tag, ".v"},     V_OUT, 1'b1);
      check({tag, ".addr"},  ADDR_OUT, a);
      check({tag, ".bytes"}, BYTES_OUT, b);
      check({tag, ".part"},  PART_OUT, p);
      check({tag, ".last"},  LAST_OUT, l);
      check({tag, ".exc"},   SEG_LIMIT_EXC_OUT, e);
   endtask

   initial begin
      RST = 1'b1; FLUSH = 1'b0; V_IN = 1'b0; READY_IN = 1'b0; WR_IN = 1'b0;
      BASE_DISP = '0; SIB_OFFSET = '0; SEG_BASE = '0; SEG_LIMIT = '0; SIZE = '0;
      cyc(); cyc();
      check("rst.v",     V_OUT, 1'b0);
      check("rst.addr",  ADDR_OUT, 32'h0);
      check("rst.bytes", BYTES_OUT, 4'h0);
      check("rst.rdy",   READY_OUT, 1'b0);
      RST = 1'b0;

      // No split: lin = 0x1000 + 0x10 + 0x4
      READY_IN = 1'b1;
      req(32'h1000, 32'h10, 32'h4, 32'hFFFF, 2'd2, 1'b1);
      #1 check("nosplit.rdy", READY_OUT, 1'b1);
      cyc(); V_IN = 1'b0;
      expect_out("nosplit", 32'h1014, 4'd4, 1'b0, 1'b1, 1'b0);
      check("nosplit.wr", WR_OUT, 1'b1);
      cyc();
      check("nosplit.empty", V_OUT, 1'b0);

      // Split: lin = 0x100E, 8 bytes -> 2 + 6
      req(32'h1000, 32'hC, 32'h2, 32'hFFFF, 2'd3, 1'b0);
      cyc(); V_IN = 1'b0;
      expect_out("split.p0", 32'h100E, 4'd2, 1'b0, 1'b0, 1'b0);
      check("split.rdy", READY_OUT, 1'b0);
      check("split.wr", WR_OUT, 1'b0);
      cyc();
      expect_out("split.p1", 32'h1010, 4'd6, 1'b1, 1'b1, 1'b0);
      cyc();
      check("split.empty", V_OUT, 1'b0);

      // Limit fault: off 0xFFFE + 3 > 0xFFFF; would otherwise split (lo=14)
      req(32'h0, 32'hFFFE, 32'h0, 32'hFFFF, 2'd2, 1'b0);
      cyc(); V_IN = 1'b0;
      expect_out("fault", 32'hFFFE, 4'd4, 1'b0, 1'b1, 1'b1);
      cyc();
      check("fault.empty", V_OUT, 1'b0);

      // Wrap past 2^32 always faults
      req(32'h0, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 2'd2, 1'b0);
      cyc(); V_IN = 1'b0;
      expect_out("wrap", 32'hFFFF_FFFE, 4'd4, 1'b0, 1'b1, 1'b1);
      cyc();

      // Exact limit and exact line end: no fault, no split
      req(32'h0, 32'hFFFC, 32'h0, 32'hFFFF, 2'd2, 1'b0);
      cyc(); V_IN = 1'b0;
      expect_out("edge", 32'hFFFC, 4'd4, 1'b0, 1'b1, 1'b0);
      cyc();

      // Backpressure on a split: part 0 stable for 3 cycles
      READY_IN = 1'b0;
      req(32'h2000, 32'hC, 32'h2, 32'hFFFF, 2'd3, 1'b0);
      cyc(); V_IN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_out($sformatf("bp.hold%0d", i), 32'h200E, 4'd2, 1'b0, 1'b0, 1'b0);
         if (i < 2) cyc();
      end
      READY_IN = 1'b1;
      cyc();
      expect_out("bp.p1", 32'h2010, 4'd6, 1'b1, 1'b1, 1'b0);
      cyc();
      check("bp.nodup", V_OUT, 1'b0);

      // Streaming: 4 back-to-back non-split requests
      for (int k = 0; k < 4; k++) begin
         req(32'h3000, 32'h100 + 32'h10 * k, 32'h0, 32'hFFFF, 2'd2, 1'b0);
         #1 check($sformatf("stream.rdy%0d", k), READY_OUT, 1'b1);
         if (k > 0) expect_out($sformatf("stream.o%0d", k - 1),
                               32'h3100 + 32'h10 * (k - 1), 4'd4, 1'b0, 1'b1, 1'b0);
         cyc();
      end
      V_IN = 1'b0;
      expect_out("stream.o3", 32'h3130, 4'd4, 1'b0, 1'b1, 1'b0);
      cyc();
      check("stream.empty", V_OUT, 1'b0);

      // FLUSH while part 0 is stalled; a V_IN in the flush cycle is ignored
      READY_IN = 1'b0;
      req(32'h4000, 32'hC, 32'h2, 32'hFFFF, 2'd3, 1'b0);
      cyc(); V_IN = 1'b0;
      expect_out("fl.p0", 32'h400E, 4'd2, 1'b0, 1'b0, 1'b0);
      FLUSH = 1'b1;
      req(32'h5000, 32'h0, 32'h0, 32'hFFFF, 2'd0, 1'b0);
      #1 check("fl.rdy", READY_OUT, 1'b0);
      cyc();
      FLUSH = 1'b0; V_IN = 1'b0; READY_IN = 1'b1;
      check("fl.v0", V_OUT, 1'b0);
      cyc();
      check("fl.v1", V_OUT, 1'b0);

      // RST at the same point clears every output
      READY_IN = 1'b0;
      req(32'h6000, 32'hC, 32'h2, 32'hFFFF, 2'd3, 1'b1);
      cyc(); V_IN = 1'b0;
      expect_out("rs.p0", 32'h600E, 4'd2, 1'b0, 1'b0, 1'b0);
      RST = 1'b1;
      cyc();
      RST = 1'b0;
      check("rs.v",     V_OUT, 1'b0);
      check("rs.addr",  ADDR_OUT, 32'h0);
      check("rs.bytes", BYTES_OUT, 4'h0);
      check("rs.part",  PART_OUT, 1'b0);
      check("rs.last",  LAST_OUT, 1'b0);
      check("rs.wr",    WR_OUT, 1'b0);
      check("rs.exc",   SEG_LIMIT_EXC_OUT, 1'b0);
      READY_IN = 1'b1;
      cyc();
      check("rs.nop1", V_OUT, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/agen_split_unit.md
# agen_split_unit

Parametrised second-stage address generator. Each accepted request produces a linear memory address (segment base + base/displacement + scaled index) and a segment-limit check. Any access that straddles a LINE_BYTES boundary is split into two sequential, aligned-part memory requests. It sits between the AG1 latch and the ME-stage memory port, and replaces the purely combinational stage-2 adder/mux with a registered stage that has a valid/ready handshake.

## Interface
- ADDR_W, 32, address/offset width in bits.
- LINE_BYTES, 16, split granule in bytes; power of 2, minimum 8.
- CHECK_LIMIT, 1, 1 enables the segment-limit check; 0 forces SEG_LIMIT_EXC_OUT to 0.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  synchronous pipeline flush.
- V_IN  in  1  request valid.
- READY_OUT  out  1  this block can accept a request this cycle.
- BASE_DISP  in  ADDR_W  base + displacement offset.
- SIB_OFFSET  in  ADDR_W  scaled index offset.
- SEG_BASE  in  ADDR_W  segment base.
- SEG_LIMIT  in  ADDR_W  segment limit (inclusive, byte granular).
- SIZE  in  2  access size; byte count = 1<<SIZE, giving 1, 2, 4 or 8.
- WR_IN  in  1  1 = write, 0 = read.
- V_OUT  out  1  output request valid.
- READY_IN  in  1  downstream accepts the output this cycle.
- ADDR_OUT  out  ADDR_W  linear address of the current part.
- BYTES_OUT  out  4  byte count of the current part (1..8).
- PART_OUT  out  1  0 = first or only part, 1 = second part.
- LAST_OUT  out  1  current part is the final part of the request.
- WR_OUT  out  1  registered WR_IN.
- SEG_LIMIT_EXC_OUT  out  1  request violates the segment limit.

## Operation
- Offset `off` = BASE_DISP + SIB_OFFSET, taken mod 2^ADDR_W.
- Linear address `lin` = SEG_BASE + off, taken mod 2^ADDR_W.
- Byte count `n` = 1<<SIZE.
- Limit check: compute off + n − 1 in ADDR_W+1 bits. The exception fires if that value > SEG_LIMIT, zero-extended. Wrap past 2^ADDR_W therefore always faults.
- Split: with `lo` = lin mod LINE_BYTES, a split occurs when lo + n > LINE_BYTES and there is no exception.
  - Part 0: ADDR = lin, BYTES = LINE_BYTES − lo.
  - Part 1: ADDR = lin + (LINE_BYTES − lo), which is line-aligned; BYTES = n − part-0 bytes.
- Faulting request: never split. It is emitted as one part with BYTES = n, LAST = 1, EXC = 1.
- FSM states:
  - EMPTY: V_OUT = 0.
  - HOLD: output valid; last part.
  - SPLIT1: output valid; part 0 shown, part 1 pending in a register.
- Transitions:
  - EMPTY or HOLD&READY_IN, with V_IN: load request. Go to SPLIT1 if a split occurs, else HOLD.
  - HOLD&READY_IN, no V_IN: go to EMPTY.
  - SPLIT1&READY_IN: show part 1 (PART_OUT = 1, LAST_OUT = 1) and go to HOLD.
  - Otherwise: hold all outputs stable.
- READY_OUT = !FLUSH && (state==EMPTY || (state==HOLD && READY_IN)). It is combinational and 0 in SPLIT1.
- FLUSH: next state EMPTY, the pending part is dropped, and V_IN is ignored in that cycle. FLUSH has priority over the handshake and equals RST in effect on state.

## Timing
- Latency: a request accepted in cycle t appears as V_OUT = 1 in cycle t+1.
- Throughput: 1 request/cycle for non-split requests under continuous READY_IN. A split request occupies 2 output cycles.
- Output fields and V_OUT do not change while V_OUT && !READY_IN.
- Reset (RST high at an edge): state EMPTY and all outputs 0 after the edge, i.e. V_OUT, ADDR_OUT, BYTES_OUT, PART_OUT, LAST_OUT, WR_OUT and SEG_LIMIT_EXC_OUT. READY_OUT is 0 while RST is high.
- Reset or FLUSH mid-split: part 1 is never emitted. Downstream sees V_OUT = 0 the next cycle.
- Simultaneous READY_IN (retiring a last part) and V_IN: back-to-back, with no bubble.

## Test plan
- No split: SEG_BASE=0x1000, BASE_DISP=0x10, SIB_OFFSET=0x4, SIZE=2, SEG_LIMIT=0xFFFF, READY_IN=1 -> next cycle V_OUT=1, ADDR_OUT=0x1014, BYTES_OUT=4, PART_OUT=0, LAST_OUT=1, EXC=0.
- Split: SEG_BASE=0x1000, BASE_DISP=0xC, SIB_OFFSET=0x2, SIZE=3 -> cycle 1: ADDR_OUT=0x100E, BYTES=2, PART=0, LAST=0, READY_OUT=0; cycle 2: ADDR_OUT=0x1010, BYTES=6, PART=1, LAST=1.
- Limit fault: off=0xFFFE, SIZE=2, SEG_LIMIT=0xFFFF -> one output with EXC=1, BYTES=4, LAST=1, no split. Also off=0xFFFFFFFE, SIZE=2, SEG_LIMIT=0xFFFFFFFF -> EXC=1 (wrap).
- Backpressure: split request with READY_IN=0 for 3 cycles -> part-0 fields stable for all 3 cycles; part 1 appears one cycle after READY_IN rises; no duplicate or lost parts.
- Streaming: 4 non-split requests on consecutive cycles with READY_IN=1 -> 4 consecutive V_OUT cycles, addresses in order, READY_OUT held 1.
- Flush/reset: FLUSH in the cycle part 0 is shown with READY_IN=0 -> next cycle V_OUT=0 and part 1 never appears. RST at the same point -> all outputs 0 after the edge.
